// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
//
// Purpose
//   Produces the Selector codes for the two EX-stage operand muxes of the
//   RV32 5-stage pipeline. The unit sits in ID and follows the destination
//   register, register-write and load flags of the instructions in flight.
//   It detects read-after-write hazards, which are resolved by forwarding,
//   and load-use hazards, which are resolved by a single stall cycle. It
//   inserts a bubble into EX on a stall or on a branch flush. The selector
//   outputs are registered, so they are valid in EX exactly one clock after
//   the instruction was presented in ID.
//
// Parameters
//   REG_AW  register address width
//   CNT_W   stall counter width (used only when HFU_STALL_CNT_EN is defined)
//
// Ports
//   clk          in   pipeline clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   id_valid     in   ID holds a real instruction
//   id_rs1       in   ID source register 1
//   id_rs2       in   ID source register 2
//   id_rd        in   ID destination register
//   id_regwrite  in   ID instruction writes rd
//   id_memread   in   ID instruction is a load
//   flush        in   branch/jump taken in EX; kill the ID instruction
//   fwd_sel_a    out  EX operand A select: 0=ID/EX reg, 1=WB data, 2=MEM ALU result
//   fwd_sel_b    out  EX operand B select, same encoding
//   stall        out  combinational; hold PC and IF/ID this cycle
//   ex_bubble    out  registered; the instruction now in EX is a bubble
//   stall_count  out  stall cycles since reset (only with HFU_STALL_CNT_EN)
//
// Configuration
//   HFU_STALL_CNT_EN  when defined, the unit adds the stall_count port and a
//                     free-running counter of stall cycles. The counter wraps
//                     to zero and does not saturate.
// ---------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              stall,
`ifdef HFU_STALL_CNT_EN
  output logic              ex_bubble,
  output logic [CNT_W-1:0]  stall_count
`else
  output logic              ex_bubble
`endif
);

  localparam logic [1:0] SEL_IDEX = 2'd0;
  localparam logic [1:0] SEL_WB   = 2'd1;
  localparam logic [1:0] SEL_MEM  = 2'd2;

  // Tracking state for the EX and MEM stages. The WB stage is not tracked:
  // forwarding never reaches beyond WB, because the register file
  // write-through already covers WB->ID. The MEM stage also does not need
  // its load flag, because a load in MEM forwards the same way as an ALU
  // result in MEM.
  logic              ex_v;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_rw;
  logic              ex_mr;
  logic              mem_v;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_rw;

  logic              issue;
  logic              load_use;
  logic [1:0]        sel_a_next;
  logic [1:0]        sel_b_next;

  // A tracked entry hits a source register only when it is a real writer of
  // a non-zero register. x0 is hard-wired to zero, so it never forwards.
  function automatic logic entry_hit(input logic              v,
                                     input logic              rw,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
    return v & rw & (rd != '0) & (rd == rs);
  endfunction

  // Choose the selector for a single source operand. The EX entry is the
  // younger producer and holds the newer value, so it takes priority. Next
  // cycle that entry sits in MEM, which is why it maps to the MEM ALU result
  // path. A MEM hit maps to the WB data path for the same reason.
  function automatic logic [1:0] pick_sel(input logic [REG_AW-1:0] rs);
    if (entry_hit(ex_v, ex_rw, ex_rd, rs))
      return SEL_MEM;
    else if (entry_hit(mem_v, mem_rw, mem_rd, rs))
      return SEL_WB;
    else
      return SEL_IDEX;
  endfunction

  // Load-use detection. A load in EX has no data until MEM ends, so a
  // dependent instruction in ID must wait one cycle. A flush kills the ID
  // instruction, which removes the hazard, so flush overrides the stall.
  always_comb begin
    load_use = ex_v & ex_mr & (ex_rd != '0) &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    stall    = id_valid & ~flush & load_use;
    issue    = id_valid & ~flush & ~stall;
  end

  // Next selector values. Any cycle that puts a bubble into EX loads the
  // neutral select, so a dead slot never requests a forward.
  always_comb begin
    sel_a_next = SEL_IDEX;
    sel_b_next = SEL_IDEX;
    if (issue) begin
      sel_a_next = pick_sel(id_rs1);
      sel_b_next = pick_sel(id_rs2);
    end
  end

  // Pipeline tracking plus the registered outputs. Reset clears every
  // tracked entry. An empty EX makes stall fall to zero at once, even when
  // reset arrives in the middle of a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v      <= 1'b0;
      ex_rd     <= '0;
      ex_rw     <= 1'b0;
      ex_mr     <= 1'b0;
      mem_v     <= 1'b0;
      mem_rd    <= '0;
      mem_rw    <= 1'b0;
      fwd_sel_a <= SEL_IDEX;
      fwd_sel_b <= SEL_IDEX;
      ex_bubble <= 1'b1;
    end else begin
      mem_v     <= ex_v;
      mem_rd    <= ex_rd;
      mem_rw    <= ex_rw;
      ex_v      <= issue;
      ex_rd     <= issue ? id_rd : '0;
      ex_rw     <= issue & id_regwrite;
      ex_mr     <= issue & id_memread;
      fwd_sel_a <= sel_a_next;
      fwd_sel_b <= sel_b_next;
      ex_bubble <= ~issue;
    end
  end

`ifdef HFU_STALL_CNT_EN
  // Stall cycle counter. It wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (stall)
      stall_count <= stall_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Self-checking bench for hazard_forward_unit. The reference model keeps a
// short history of the instructions that entered EX, youngest first. From
// that history it derives the expected forwarding, load-use stall and bubble
// behaviour. Directed scenarios run first, followed by a randomized
// instruction stream.
// ---------------------------------------------------------------------------
module tb_hazard_forward_unit;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              flush;
  logic [1:0]        fwd_sel_a;
  logic [1:0]        fwd_sel_b;
  logic              stall;
  logic              ex_bubble;
`ifdef HFU_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_count;
`endif

  hazard_forward_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .fwd_sel_a   (fwd_sel_a),
    .fwd_sel_b   (fwd_sel_b),
    .stall       (stall),
`ifdef HFU_STALL_CNT_EN
    .ex_bubble   (ex_bubble),
    .stall_count (stall_count)
`else
    .ex_bubble   (ex_bubble)
`endif
  );

  always #5 clk = ~clk;

  // One history record per clock: the instruction that entered EX that
  // cycle. A bubble is recorded as not valid. hist[0] is the youngest record.
  typedef struct {
    bit              v;
    logic [REG_AW-1:0] rd;
    bit              rw;
    bit              mr;
  } instr_t;

  instr_t hist[$];
  int     checks = 0;
  int     passes = 0;
  longint exp_cnt = 0;
  bit     last_stall = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got === exp)
      passes++;
    else
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected selector: find the most recent real writer of rs among the last
  // two instructions that entered EX. Age 0 is in MEM by the time the
  // consumer runs in EX, so it maps to 2. Age 1 maps to 1.
  function automatic logic [1:0] model_sel(input logic [REG_AW-1:0] rs);
    for (int age = 0; age < 2 && age < hist.size(); age++)
      if (hist[age].v && hist[age].rw && rs != 0 && hist[age].rd == rs)
        return (age == 0) ? 2'd2 : 2'd1;
    return 2'd0;
  endfunction

  function automatic bit model_stall();
    if (hist.size() == 0) return 1'b0;
    return id_valid && !flush && hist[0].v && hist[0].mr && hist[0].rd != 0 &&
           (hist[0].rd == id_rs1 || hist[0].rd == id_rs2);
  endfunction

  // Present one instruction in ID for one clock and check the unit's
  // response against the model.
  task automatic applyStimulus(input bit v, input logic [REG_AW-1:0] rs1,
                               input logic [REG_AW-1:0] rs2,
                               input logic [REG_AW-1:0] rd,
                               input bit rw, input bit mr, input bit fl);
    bit        exp_stall;
    bit        issue;
    logic [1:0] exp_a;
    logic [1:0] exp_b;
    instr_t    slot;
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_regwrite = rw; id_memread = mr; flush = fl;
    #1;
    exp_stall = model_stall();
    checkOutput("stall", {63'd0, stall}, {63'd0, exp_stall});
    issue = v && !fl && !exp_stall;
    exp_a = issue ? model_sel(rs1) : 2'd0;
    exp_b = issue ? model_sel(rs2) : 2'd0;
    slot.v = issue; slot.rd = rd; slot.rw = issue && rw; slot.mr = issue && mr;
    @(posedge clk);
    #1;
    if (exp_stall) exp_cnt++;
    last_stall = exp_stall;
    hist.push_front(slot);
    if (hist.size() > 2) void'(hist.pop_back());
    checkOutput("fwd_sel_a", {62'd0, fwd_sel_a}, {62'd0, exp_a});
    checkOutput("fwd_sel_b", {62'd0, fwd_sel_b}, {62'd0, exp_b});
    checkOutput("ex_bubble", {63'd0, ex_bubble}, {63'd0, !issue});
`ifdef HFU_STALL_CNT_EN
    checkOutput("stall_count", {32'd0, stall_count}, exp_cnt & 64'hFFFF_FFFF);
`endif
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_sel_a"}, {62'd0, fwd_sel_a}, 64'd0);
    checkOutput({tag, "_sel_b"}, {62'd0, fwd_sel_b}, 64'd0);
    checkOutput({tag, "_stall"}, {63'd0, stall}, 64'd0);
    checkOutput({tag, "_bubble"}, {63'd0, ex_bubble}, 64'd1);
`ifdef HFU_STALL_CNT_EN
    checkOutput({tag, "_count"}, {32'd0, stall_count}, 64'd0);
`endif
  endtask

  // Asynchronous reset pulse, applied away from the clock edge.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkResetValues("reset");
    hist.delete();
    exp_cnt = 0;
    last_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [REG_AW-1:0] r1, r2, rd;
    bit v, rw, mr, fl;
    rst_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_regwrite = 0; id_memread = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("init");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: add x5 ; sub x6,x5,x1
    applyStimulus(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    applyStimulus(1, 5'd5, 5'd1, 5'd6, 1, 0, 0);
    checkOutput("t1_sel_a", {62'd0, fwd_sel_a}, 64'd2);
    checkOutput("t1_sel_b", {62'd0, fwd_sel_b}, 64'd0);

    // 2: add x5 ; nop ; or x7,x2,x5
    applyStimulus(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    applyStimulus(1, 5'd2, 5'd5, 5'd7, 1, 0, 0);
    checkOutput("t2_sel_a", {62'd0, fwd_sel_a}, 64'd0);
    checkOutput("t2_sel_b", {62'd0, fwd_sel_b}, 64'd1);

    // 3: add x5 ; addi x5 ; and x8,x5,x5  (younger producer wins)
    applyStimulus(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    applyStimulus(1, 5'd1, 5'd0, 5'd5, 1, 0, 0);
    applyStimulus(1, 5'd5, 5'd5, 5'd8, 1, 0, 0);
    checkOutput("t3_sel_a", {62'd0, fwd_sel_a}, 64'd2);
    checkOutput("t3_sel_b", {62'd0, fwd_sel_b}, 64'd2);

    // 4: lw x7 ; add x9,x1,x7  (one stall cycle, then WB forward)
    doReset();
    applyStimulus(1, 5'd1, 5'd0, 5'd7, 1, 1, 0);
    id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd7; id_rd = 5'd9;
    id_regwrite = 1; id_memread = 0; flush = 0;
    #1;
    checkOutput("t4_stall", {63'd0, stall}, 64'd1);
    applyStimulus(1, 5'd1, 5'd7, 5'd9, 1, 0, 0);
    checkOutput("t4_bubble", {63'd0, ex_bubble}, 64'd1);
    applyStimulus(1, 5'd1, 5'd7, 5'd9, 1, 0, 0);
    checkOutput("t4_sel_b", {62'd0, fwd_sel_b}, 64'd1);
    checkOutput("t4_stall_after", {63'd0, stall}, 64'd0);
`ifdef HFU_STALL_CNT_EN
    checkOutput("t4_count", {32'd0, stall_count}, 64'd1);
`endif

    // 5: addi x0,x1,3 ; add x2,x0,x0  (x0 never forwards)
    applyStimulus(1, 5'd1, 5'd0, 5'd0, 1, 0, 0);
    applyStimulus(1, 5'd0, 5'd0, 5'd2, 1, 0, 0);
    checkOutput("t5_sel_a", {62'd0, fwd_sel_a}, 64'd0);
    checkOutput("t5_sel_b", {62'd0, fwd_sel_b}, 64'd0);

    // 6: load-use with flush in the same cycle
    applyStimulus(1, 5'd1, 5'd0, 5'd7, 1, 1, 0);
    applyStimulus(1, 5'd1, 5'd7, 5'd9, 1, 0, 1);
    checkOutput("t6_bubble", {63'd0, ex_bubble}, 64'd1);
    checkOutput("t6_sel_b", {62'd0, fwd_sel_b}, 64'd0);

    // Reset in the middle of a stall drops the stall at once.
    applyStimulus(1, 5'd1, 5'd0, 5'd7, 1, 1, 0);
    id_valid = 1; id_rs1 = 5'd7; id_rs2 = 5'd3; id_rd = 5'd9;
    id_regwrite = 1; id_memread = 0; flush = 0;
    #1;
    checkOutput("midrst_stall_before", {63'd0, stall}, 64'd1);
    doReset();

    // Randomized stream. A stalled instruction is held in ID, as the real
    // pipeline would hold it.
    r1 = 0; r2 = 0; rd = 0; v = 0; rw = 0; mr = 0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        v  = ($urandom_range(9) != 0);
        r1 = REG_AW'($urandom_range(7));
        r2 = REG_AW'($urandom_range(7));
        rd = REG_AW'($urandom_range(7));
        rw = ($urandom_range(4) != 0);
        mr = ($urandom_range(2) == 0);
      end
      fl = ($urandom_range(9) == 0);
      applyStimulus(v, r1, r2, rd, rw, mr, fl);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
